// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - request/response and word-memory port bundle for lsu_mem_ctrl
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_MemWrite;
    logic        mem_MemRead;
    logic [31:0] mem_Read_data;

    // Controller side: consumes CPU requests and memory read data, drives everything else
    modport master (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_Read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_address, mem_write_data, mem_MemWrite, mem_MemRead
    );

    // Environment side: CPU datapath plus data memory
    modport slave (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_Read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_address, mem_write_data, mem_MemWrite, mem_MemRead
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - RV32I load/store initiator with read-modify-write sub-word stores
module lsu_mem_ctrl #(
    parameter int ADDR_LIMIT = 1024
) (
    input  logic           clk,
    input  logic           rst,
    lsu_mem_ctrl_if.master bus
);
    localparam logic [2:0]  F3_B  = 3'b000;
    localparam logic [2:0]  F3_H  = 3'b001;
    localparam logic [2:0]  F3_W  = 3'b010;
    localparam logic [2:0]  F3_BU = 3'b100;
    localparam logic [2:0]  F3_HU = 3'b101;
    localparam logic [32:0] LIMIT = 33'(ADDR_LIMIT);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_error_q, resp_error_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_write_data_q, mem_write_data_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;

    logic [31:0] in_aligned;
    logic [32:0] in_last_byte;
    logic        in_error;

    // Sign/zero-extend the addressed lane of a little-endian word
    function automatic logic [31:0] extract_load(input logic [31:0] w, input logic [1:0] a,
                                                 input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_BU:   return {24'd0, b};
            F3_HU:   return {16'd0, h};
            default: return w;
        endcase
    endfunction

    // Replace the addressed lane of the captured word with the store data
    function automatic logic [31:0] merge_store(input logic [31:0] w, input logic [31:0] d,
                                                input logic [1:0] a, input logic [2:0] f3);
        logic [31:0] r;
        r = w;
        if (f3 == F3_B) begin
            case (a)
                2'd0:    r[7:0]   = d[7:0];
                2'd1:    r[15:8]  = d[7:0];
                2'd2:    r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end else if (f3 == F3_H) begin
            if (a[1]) r[31:16] = d[15:0];
            else      r[15:0]  = d[15:0];
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Reject illegal codes, misalignment and out-of-range words on the incoming request
    always_comb begin
        in_aligned   = {bus.req_addr[31:2], 2'b00};
        in_last_byte = {1'b0, in_aligned} + 33'd3;
        in_error     = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                       (bus.req_funct3 == 3'b111) ||
                       (bus.req_write && (bus.req_funct3 == F3_BU || bus.req_funct3 == F3_HU)) ||
                       (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                       (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00) ||
                       (in_last_byte >= LIMIT);
    end

    // Next state and next registered outputs; strobes default low so they last one state
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        funct3_d         = funct3_q;
        write_d          = write_q;
        wdata_d          = wdata_q;
        req_ready_d      = 1'b0;
        resp_valid_d     = 1'b0;
        resp_rdata_d     = 32'd0;
        resp_error_d     = 1'b0;
        mem_address_d    = 32'd0;
        mem_write_data_d = 32'd0;
        mem_read_d       = 1'b0;
        mem_write_d      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid) begin
                    addr_d      = bus.req_addr;
                    funct3_d    = bus.req_funct3;
                    write_d     = bus.req_write;
                    wdata_d     = bus.req_wdata;
                    req_ready_d = 1'b0;
                    if (in_error) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else if (bus.req_write && bus.req_funct3 == F3_W) begin
                        state_d          = WR;
                        mem_write_d      = 1'b1;
                        mem_address_d    = in_aligned;
                        mem_write_data_d = bus.req_wdata;
                    end else begin
                        state_d       = RD;
                        mem_read_d    = 1'b1;
                        mem_address_d = in_aligned;
                    end
                end
            end
            RD: begin
                // The read word is captured here: extracted for loads, merged for SB/SH
                if (write_q) begin
                    state_d          = WR;
                    mem_write_d      = 1'b1;
                    mem_address_d    = {addr_q[31:2], 2'b00};
                    mem_write_data_d = merge_store(bus.mem_Read_data, wdata_q, addr_q[1:0], funct3_q);
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = extract_load(bus.mem_Read_data, addr_q[1:0], funct3_q);
                end
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // Controller state and registered outputs; reset drops strobes immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            addr_q           <= 32'd0;
            funct3_q         <= 3'd0;
            write_q          <= 1'b0;
            wdata_q          <= 32'd0;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= 32'd0;
            resp_error_q     <= 1'b0;
            mem_address_q    <= 32'd0;
            mem_write_data_q <= 32'd0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            funct3_q         <= funct3_d;
            write_q          <= write_d;
            wdata_q          <= wdata_d;
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            resp_rdata_q     <= resp_rdata_d;
            resp_error_q     <= resp_error_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_rdata     = resp_rdata_q;
    assign bus.resp_error     = resp_error_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_write_data = mem_write_data_q;
    assign bus.mem_MemRead    = mem_read_q;
    assign bus.mem_MemWrite   = mem_write_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed scoreboard bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;
    logic clk;
    logic rst;
    lsu_mem_ctrl_if bus ();

    lsu_mem_ctrl #(.ADDR_LIMIT(1024)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:255];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    int          resp_seen = 0;
    logic [31:0] last_rd_addr = 32'd0;
    logic [31:0] last_wr_addr = 32'd0;
    logic [31:0] last_wr_data = 32'd0;

    assign bus.mem_Read_data = bus.mem_MemRead ? mem[bus.mem_address[9:2]] : 32'hx;

    always @(posedge clk)
        if (bus.mem_MemWrite) mem[bus.mem_address[9:2]] <= bus.mem_write_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Strobe monitor and scoreboard pop, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.mem_MemRead) begin
            rd_cnt++;
            last_rd_addr = bus.mem_address;
        end
        if (bus.mem_MemWrite) begin
            wr_cnt++;
            last_wr_addr = bus.mem_address;
            last_wr_data = bus.mem_write_data;
        end
        if (bus.mem_MemRead && bus.mem_MemWrite) both_cnt++;
        if (bus.resp_valid) begin
            resp_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_rdata", bus.resp_rdata, e.rdata);
                chk("resp_error", {31'd0, bus.resp_error}, {31'd0, e.err});
            end
        end
    end

    task automatic do_req(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_lat, input int exp_rds, input int exp_wrs);
        int lat;
        int rd0;
        int wr0;
        int resp0;
        @(negedge clk);
        chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        exp_q.push_back('{rdata: exp_rd, err: exp_err});
        rd0   = rd_cnt;
        wr0   = wr_cnt;
        resp0 = resp_seen;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        @(posedge clk);
        #1;
        chk({tag, "_reads"}, 32'(rd_cnt - rd0), 32'(exp_rds));
        chk({tag, "_writes"}, 32'(wr_cnt - wr0), 32'(exp_wrs));
        chk({tag, "_resps"}, 32'(resp_seen - resp0), 32'd1);
    endtask

    initial begin
        bit exp_rdy [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        bit exp_rsp [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
        mem[4]   <= 32'h1111_1111;
        mem[255] <= 32'hCAFE_F00D;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_error", {31'd0, bus.resp_error}, 32'd0);
        chk("rst_mem_read", {31'd0, bus.mem_MemRead}, 32'd0);
        chk("rst_mem_write", {31'd0, bus.mem_MemWrite}, 32'd0);
        chk("rst_mem_address", bus.mem_address, 32'd0);
        chk("rst_mem_wdata", bus.mem_write_data, 32'd0);
        rst = 1'b0;

        // Reset landing in the WR cycle of a word store
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("midrst_wr_before", {31'd0, bus.mem_MemWrite}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_wr_dropped", {31'd0, bus.mem_MemWrite}, 32'd0);
        chk("midrst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("midrst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_word_kept", mem[4], 32'h1111_1111);
        @(negedge clk);
        rst = 1'b0;

        do_req("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0, 2, 0, 1);
        chk("sw_10_addr", last_wr_addr, 32'h10);
        chk("sw_10_data", last_wr_data, 32'hDEAD_BEEF);
        do_req("lw_10", 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 2, 1, 0);
        do_req("lb_13", 1'b0, 3'b000, 32'h13, 32'd0, 32'hFFFF_FFDE, 1'b0, 2, 1, 0);
        do_req("lbu_13", 1'b0, 3'b100, 32'h13, 32'd0, 32'h0000_00DE, 1'b0, 2, 1, 0);
        do_req("lh_12", 1'b0, 3'b001, 32'h12, 32'd0, 32'hFFFF_DEAD, 1'b0, 2, 1, 0);
        do_req("lhu_10", 1'b0, 3'b101, 32'h10, 32'd0, 32'h0000_BEEF, 1'b0, 2, 1, 0);

        do_req("sb_11", 1'b1, 3'b000, 32'h11, 32'h0000_0055, 32'd0, 1'b0, 3, 1, 1);
        chk("sb_11_rd_addr", last_rd_addr, 32'h10);
        chk("sb_11_data", last_wr_data, 32'hDEAD_55EF);
        do_req("sh_12", 1'b1, 3'b001, 32'h12, 32'hFFFF_1234, 32'd0, 1'b0, 3, 1, 1);
        chk("sh_12_word", mem[4], 32'h1234_55EF);
        do_req("lw_10_after", 1'b0, 3'b010, 32'h10, 32'd0, 32'h1234_55EF, 1'b0, 2, 1, 0);

        do_req("lw_mis_12", 1'b0, 3'b010, 32'h12, 32'd0, 32'd0, 1'b1, 1, 0, 0);
        do_req("sh_mis_11", 1'b1, 3'b001, 32'h11, 32'h0000_BBBB, 32'd0, 1'b1, 1, 0, 0);

        do_req("lw_1020", 1'b0, 3'b010, 32'd1020, 32'd0, 32'hCAFE_F00D, 1'b0, 2, 1, 0);
        do_req("lw_1024", 1'b0, 3'b010, 32'd1024, 32'd0, 32'd0, 1'b1, 1, 0, 0);
        do_req("sb_1023", 1'b1, 3'b000, 32'd1023, 32'h0000_0077, 32'd0, 1'b0, 3, 1, 1);
        chk("sb_1023_word", mem[255], 32'h77FE_F00D);
        do_req("sb_1024", 1'b1, 3'b000, 32'd1024, 32'h0000_0077, 32'd0, 1'b1, 1, 0, 0);
        do_req("sw_hi", 1'b1, 3'b010, 32'hFFFF_FFFC, 32'h1, 32'd0, 1'b1, 1, 0, 0);

        do_req("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'd0, 32'd0, 1'b1, 1, 0, 0);
        do_req("st_f3_100", 1'b1, 3'b100, 32'h10, 32'h1, 32'd0, 1'b1, 1, 0, 0);
        chk("st_f3_100_word", mem[4], 32'h1234_55EF);

        // req_valid held across two loads; inputs change while the second is in flight
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h10;
        exp_q.push_back('{rdata: 32'h1234_55EF, err: 1'b0});
        exp_q.push_back('{rdata: 32'h1234_55EF, err: 1'b0});
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("b2b_ready_%0d", i), {31'd0, bus.req_ready}, {31'd0, exp_rdy[i]});
            chk($sformatf("b2b_resp_%0d", i), {31'd0, bus.resp_valid}, {31'd0, exp_rsp[i]});
            if (i == 3) begin
                bus.req_valid = 1'b0;
                bus.req_addr  = 32'h3FC;
            end
            @(posedge clk);
            #1;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("strobes_exclusive", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
